// File: rtl/auto_cal_host_pkg.sv
// -----------------------------------------------------------------------------
// auto_cal_host_pkg
// Shared definitions for the Auto_Cal initiator: FSM state encoding, default
// parameter values and width-derived helpers.
// -----------------------------------------------------------------------------
package auto_cal_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_KICK   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DROP   = 3'd4,
    ST_REPORT = 3'd5
  } state_e;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 1024;
  localparam int unsigned LEN_W_DEF      = ADDR_WIDTH_DEF + 1;

  // A run length must be able to express the full RAM capacity, 2^ADDR_WIDTH.
  function automatic int unsigned len_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/auto_cal_host_sum_accum.sv
// -----------------------------------------------------------------------------
// sum_accum
// Clear/enable accumulator, sum modulo 2^WIDTH (carry out discarded).
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear (wins over en_i)
//   en_i          : add data_i to the running sum this cycle
//   data_i        : addend
//   sum_o         : registered running sum
// -----------------------------------------------------------------------------
module sum_accum
  import auto_cal_host_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] sum_o
);

  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;

  // Next sum: clear has priority, otherwise add on enable.
  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + data_i;
    end else begin
      sum_d = sum_q;
    end
  end

  // Sum register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/auto_cal_host.sv
// -----------------------------------------------------------------------------
// auto_cal_host
// Initiator side of the Auto_Cal start/done handshake. Loads a burst of
// operands into the calculator RAM, raises start, waits for done (bounded by
// TIMEOUT), captures the returned sum and compares it with a local sum.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   go_i, len_i              : run request pulse and word count (sampled on go)
//   in_valid_i/in_data_i/in_ready_o : operand stream
//   mem_we_o/mem_addr_o/mem_wdata_o  : RAM write port (combinational)
//   cal_start_o, cal_done_i, cal_sum_i : Auto_Cal handshake
//   busy_o                   : high outside IDLE
//   res_valid_o              : one-cycle result strobe
//   res_sum_o/res_match_o/res_timeout_o : held result of the last run
// -----------------------------------------------------------------------------
module auto_cal_host
  import auto_cal_host_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF      // must be >= 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  go_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  cal_start_o,
  input  logic                  cal_done_i,
  input  logic [DATA_WIDTH-1:0] cal_sum_i,
  output logic                  busy_o,
  output logic                  res_valid_o,
  output logic [DATA_WIDTH-1:0] res_sum_o,
  output logic                  res_match_o,
  output logic                  res_timeout_o
);

  localparam int unsigned LEN_W = len_width(ADDR_WIDTH);
  localparam int unsigned TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(2 ** ADDR_WIDTH);
  // The start-high window counts the KICK cycle too, so WAIT gives up after
  // TIMEOUT-1 cycles: cal_start is high for at most TIMEOUT cycles in total.
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 2);

  state_e                state_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      cnt_q;
  logic [TO_W-1:0]       tcnt_q;
  logic                  in_ready_q;
  logic                  cal_start_q;
  logic                  busy_q;
  logic                  res_valid_q;
  logic [DATA_WIDTH-1:0] res_sum_q;
  logic                  res_match_q;
  logic                  res_timeout_q;

  logic                  xfer_s;
  logic                  acc_clr_s;
  logic [LEN_W-1:0]      len_clamp_s;
  logic [DATA_WIDTH-1:0] exp_sum_s;

  // Handshake decode, run-start decode and length clamp.
  always_comb begin
    xfer_s    = in_valid_i & in_ready_q;
    acc_clr_s = (state_q == ST_IDLE) & go_i;
    if (len_i > LEN_MAX) begin
      len_clamp_s = LEN_MAX;
    end else begin
      len_clamp_s = len_i;
    end
  end

  sum_accum #(
    .WIDTH (DATA_WIDTH)
  ) u_sum_accum (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (acc_clr_s),
    .en_i   (xfer_s),
    .data_i (in_data_i),
    .sum_o  (exp_sum_s)
  );

  // RAM write port follows the accepted transfer in the same cycle; address
  // and data are forced to zero when no write is happening.
  assign mem_we_o    = xfer_s;
  assign mem_addr_o  = xfer_s ? cnt_q[ADDR_WIDTH-1:0] : '0;
  assign mem_wdata_o = xfer_s ? in_data_i : '0;

  // Control FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      cnt_q         <= '0;
      tcnt_q        <= '0;
      in_ready_q    <= 1'b0;
      cal_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_sum_q     <= '0;
      res_match_q   <= 1'b0;
      res_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go_i) begin
            len_q  <= len_clamp_s;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (len_clamp_s == '0) begin
              cal_start_q <= 1'b1;
              state_q     <= ST_KICK;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (xfer_s) begin
            cnt_q <= cnt_q + LEN_W'(1);
            // Start rises the cycle after the last write, so the RAM
            // holds every operand before Auto_Cal sees start.
            if (cnt_q == (len_q - LEN_W'(1))) begin
              in_ready_q  <= 1'b0;
              cal_start_q <= 1'b1;
              state_q     <= ST_KICK;
            end
          end
        end
        ST_KICK: begin
          tcnt_q  <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done that is already high here is taken as the answer.
          if (cal_done_i) begin
            res_sum_q     <= cal_sum_i;
            res_match_q   <= (cal_sum_i == exp_sum_s);
            res_timeout_q <= 1'b0;
            cal_start_q   <= 1'b0;
            state_q       <= ST_DROP;
          end else if (tcnt_q == TO_LAST) begin
            res_sum_q     <= '0;
            res_match_q   <= 1'b0;
            res_timeout_q <= 1'b1;
            cal_start_q   <= 1'b0;
            state_q       <= ST_DROP;
          end else begin
            tcnt_q <= tcnt_q + TO_W'(1);
          end
        end
        ST_DROP: begin
          if (!cal_done_i) begin
            res_valid_q <= 1'b1;
            state_q     <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          in_ready_q  <= 1'b0;
          cal_start_q <= 1'b0;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o    = in_ready_q;
  assign cal_start_o   = cal_start_q;
  assign busy_o        = busy_q;
  assign res_valid_o   = res_valid_q;
  assign res_sum_o     = res_sum_q;
  assign res_match_o   = res_match_q;
  assign res_timeout_o = res_timeout_q;

endmodule
